image_scale_nearest_seq: RTL and testbench

//  Raster sequencer for the nearest-neighbour upscaling path. On a start pulse it

---
 rtl/image_proc_pkg.sv | 8 +
 rtl/image_scale_nearest_seq_if.sv | 10 +
 rtl/image_scale_nearest_seq_raster_counter.sv | 28 ++
 rtl/image_scale_nearest_seq.sv | 58 +++++
 tb/tb_image_scale_nearest_seq.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/image_proc_pkg.sv
// image_proc_pkg: shared types and helpers for the image scaling path.
package image_proc_pkg;
  localparam int COORD_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int shift_of(input int s);
    return $clog2(s);
  endfunction
endpackage

// File: rtl/image_scale_nearest_seq_if.sv
// image_scale_nearest_seq_if: beat stream from the raster sequencer to the fetch/scale datapath.
interface image_scale_nearest_seq_if;
  import image_proc_pkg::*;
  logic out_valid, out_ready, sof, eol, eof, row_new;
  logic [COORD_W-1:0] dst_x, dst_y, src_x, src_y;
  modport master(output out_valid, dst_x, dst_y, src_x, src_y, sof, eol, eof, row_new,
                 input out_ready);
  modport slave(input out_valid, dst_x, dst_y, src_x, src_y, sof, eol, eof, row_new,
                output out_ready);
endinterface

// File: rtl/image_scale_nearest_seq_raster_counter.sv
// raster_counter: x/y raster counter with clear, enable, wrap and last-position flags.
module raster_counter
  import image_proc_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               x_last,
  output logic               y_last
);
  always_comb begin
    x_last = x == COORD_W'(W - 1);
    y_last = y == COORD_W'(H - 1);
    nx = clr ? '0 : en ? (x_last ? '0 : x + 1'b1) : x;
    ny = clr ? '0 : (en && x_last) ? (y_last ? '0 : y + 1'b1) : y;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) {x, y} <= '0;
    else {x, y} <= {nx, ny};
endmodule

// File: rtl/image_scale_nearest_seq.sv
// image_scale_nearest_seq: raster sequencer walking the upscaled output frame and
// emitting destination/source coordinates with framing flags under valid/ready.
module image_scale_nearest_seq
  import image_proc_pkg::*;
#(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int SCALE_FACTOR = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  image_scale_nearest_seq_if.master   bus,
  output logic                        busy,
  output logic                        done
);
  localparam int OUT_W = IMG_WIDTH * SCALE_FACTOR;
  localparam int OUT_H = IMG_HEIGHT * SCALE_FACTOR;
  localparam int SHIFT = shift_of(SCALE_FACTOR);
  localparam logic [COORD_W-1:0] ROW_MASK = COORD_W'(SCALE_FACTOR - 1);
  if (SCALE_FACTOR < 1 || SCALE_FACTOR > 16 || (SCALE_FACTOR & (SCALE_FACTOR - 1)) != 0) begin : g_bad_scale
    $error("SCALE_FACTOR must be a power of two in 1..16");
  end
  if (OUT_W < 1 || OUT_H < 1 || OUT_W > 65535 || OUT_H > 65535) begin : g_bad_size
    $error("output frame dimensions must be 1..65535");
  end
  state_t state, state_d;
  logic [COORD_W-1:0] nx, ny;
  logic x_last, y_last, run_d;
  always_comb begin
    state_d = abort ? IDLE :
              state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? ((bus.out_ready && x_last && y_last) ? DONE : RUN) : IDLE;
    run_d = state_d == RUN;
  end
  // counters clear whenever the next state leaves RUN, so IDLE/DONE always sit at (0,0)
  raster_counter #(.W(OUT_W), .H(OUT_H)) u_cnt (
    .clk(clk), .rst(rst), .clr(!run_d), .en(state == RUN && bus.out_ready),
    .x(bus.dst_x), .y(bus.dst_y), .nx(nx), .ny(ny), .x_last(x_last), .y_last(y_last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      {bus.sof, bus.eol, bus.eof, bus.row_new} <= '0;
    end else begin
      state <= state_d;
      {bus.sof, bus.eol, bus.eof, bus.row_new} <= run_d ?
        {nx == '0 && ny == '0, nx == COORD_W'(OUT_W - 1),
         nx == COORD_W'(OUT_W - 1) && ny == COORD_W'(OUT_H - 1),
         nx == '0 && (ny & ROW_MASK) == '0} : 4'b0;
    end
  assign bus.out_valid = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bus.src_x = bus.dst_x >> SHIFT;
  assign bus.src_y = bus.dst_y >> SHIFT;
endmodule

// File: tb/tb_image_scale_nearest_seq.sv
// tb_image_scale_nearest_seq: scoreboard bench over three sequencer configurations.
module tb_image_scale_nearest_seq;
  function automatic int fw(input int g); return g == 0 ? 4 : 3; endfunction
  function automatic int fh(input int g); return g == 0 ? 2 : 3; endfunction
  function automatic int fs(input int g); return g == 0 ? 2 : (g == 1 ? 1 : 4); endfunction

  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [2:0] start = '0, abort = '0, rdy = '1, ov, busy, done;
  logic [2:0][15:0] dx, dy;
  logic [67:0] q[3][$];
  int nvec = 0, nbad = 0, cyc = 0;
  int ntx[3] = '{0, 0, 0}, ndone[3] = '{0, 0, 0}, eof_cyc[3] = '{0, 0, 0};
  int base_tx[3] = '{0, 0, 0}, base_done[3] = '{0, 0, 0};
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [67:0] exp_beat(input int g, input int x, input int y);
    int s, ow, oh;
    s = fs(g); ow = fw(g) * s; oh = fh(g) * s;
    return {16'(x), 16'(y), 16'(x / s), 16'(y / s), (x == 0 && y == 0), (x == ow - 1),
            (x == ow - 1 && y == oh - 1), (x == 0 && (y % s) == 0)};
  endfunction

  task automatic push_frame(input int g, input int lim);
    int n;
    n = 0;
    base_tx[g] = ntx[g];
    base_done[g] = ndone[g];
    for (int y = 0; y < fh(g) * fs(g); y++)
      for (int x = 0; x < fw(g) * fs(g); x++)
        if (n < lim) begin
          q[g].push_back(exp_beat(g, x, y));
          n++;
        end
  endtask

  task automatic start_frame(input int g, input int lim);
    @(posedge clk); #1 start[g] = 1;
    push_frame(g, lim);
    @(posedge clk); #1 start[g] = 0;
  endtask

  task automatic finish_frame(input int g, input bit rnd, input bit poke);
    int i;
    for (i = 0; i < 2000 && ndone[g] == base_done[g]; i++) begin
      @(posedge clk); #1;
      rdy[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start[g] = poke && i == 10;
    end
    rdy[g] = 1;
    start[g] = 0;
    chk("frame_done_in_time", 68'(i < 2000), 68'd1);
    chk("beat_count", 68'(ntx[g] - base_tx[g]), 68'(fw(g) * fh(g) * fs(g) * fs(g)));
    chk("queue_drained", 68'(q[g].size()), 68'd0);
    @(negedge clk);
    chk("idle_after_frame", {ov[g], busy[g]}, 68'd0);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    image_scale_nearest_seq_if bus();
    logic [67:0] held, cur, want;
    logic stalled = 0;
    assign bus.out_ready = rdy[g];
    assign ov[g] = bus.out_valid;
    assign dx[g] = bus.dst_x;
    assign dy[g] = bus.dst_y;
    assign cur = {bus.dst_x, bus.dst_y, bus.src_x, bus.src_y, bus.sof, bus.eol, bus.eof, bus.row_new};
    image_scale_nearest_seq #(.IMG_WIDTH(fw(g)), .IMG_HEIGHT(fh(g)), .SCALE_FACTOR(fs(g))) dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]), .bus(bus),
      .busy(busy[g]), .done(done[g])
    );
    always @(negedge clk) begin
      if (stalled && bus.out_valid) chk("stall_hold", cur, held);
      stalled = bus.out_valid && !bus.out_ready;
      held = cur;
      if (bus.out_valid && bus.out_ready && !abort[g]) begin
        chk("beat_expected", 68'(q[g].size() != 0), 68'd1);
        if (q[g].size() != 0) begin
          want = q[g].pop_front();
          chk("beat", cur, want);
        end
        ntx[g]++;
        if (bus.eof) eof_cyc[g] = cyc;
      end else if (!bus.out_valid)
        chk("flags_idle", {bus.sof, bus.eol, bus.eof, bus.row_new}, 68'd0);
      if (done[g]) begin
        ndone[g]++;
        chk("done_latency", 68'(cyc), 68'(eof_cyc[g] + 1));
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk("reset_state", {ov[g], busy[g], done[g], dx[g], dy[g]}, 68'd0);
    rst = 1;
    start_frame(0, 1 << 30); finish_frame(0, 0, 0);
    start_frame(0, 1 << 30); finish_frame(0, 1, 0);
    start_frame(0, 1 << 30); finish_frame(0, 0, 1);
    // abort while (5,2) is presented: 21 beats transfer before it
    start_frame(0, 21);
    repeat (21) @(posedge clk);
    #1 abort[0] = 1;
    @(posedge clk); #1 abort[0] = 0;
    chk("abort_idle", {ov[0], busy[0], dx[0], dy[0]}, 68'd0);
    chk("abort_beats", 68'(ntx[0] - base_tx[0]), 68'd21);
    chk("abort_queue", 68'(q[0].size()), 68'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 68'(ndone[0]), 68'(base_done[0]));
    start_frame(0, 1 << 30); finish_frame(0, 0, 0);
    // start in the done cycle is ignored, start one cycle later is taken
    start_frame(0, 1 << 30);
    for (k = 0; k < 500 && !done[0]; k++) @(negedge clk);
    chk("done_seen", 68'(done[0]), 68'd1);
    start[0] = 1;
    @(negedge clk);
    chk("start_in_done_ignored", 68'(busy[0]), 68'd0);
    @(posedge clk); #1 start[0] = 0;
    push_frame(0, 1 << 30);
    finish_frame(0, 0, 0);
    start_frame(1, 1 << 30); finish_frame(1, 0, 0);
    start_frame(2, 1 << 30); finish_frame(2, 1, 0);
    // asynchronous reset mid-frame around beat 100
    start_frame(2, 1 << 30);
    for (k = 0; k < 1000 && ntx[2] - base_tx[2] < 100; k++) @(posedge clk);
    #1 rst = 0;
    #1 chk("rst_async", {ov[2], busy[2], done[2], dx[2], dy[2]}, 68'd0);
    q[2].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (4) @(negedge clk);
    chk("rst_no_done", 68'(ndone[2]), 68'(base_done[2]));
    chk("rst_idle", {ov[2], busy[2]}, 68'd0);
    start_frame(2, 1 << 30); finish_frame(2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
